// File: rtl/mpi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mpi_pkg : shared types and constants for the MPI bus-target slave     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mpi_pkg;

   localparam int c_SYNC_STAGES = 2;

   localparam logic [1:0] c_BE_NONE = 2'b00;
   localparam logic [1:0] c_BE_LOW  = 2'b01;
   localparam logic [1:0] c_BE_HIGH = 2'b10;
   localparam logic [1:0] c_BE_WORD = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_ADDR    = 4'd1,
      ST_RD_REQ  = 4'd2,
      ST_RD_WAIT = 4'd3,
      ST_RD_RPLY = 4'd4,
      ST_WR_REQ  = 4'd5,
      ST_WR_WAIT = 4'd6,
      ST_WR_RPLY = 4'd7,
      ST_DONE    = 4'd8
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mpi_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mpi_sync2 : multi-bit flop-chain synchronizer with reset preset value |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mpi_sync2
   import mpi_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [c_SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_SYNC_STAGES; i++) begin
            r_stage[i] <= RESET_VAL;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < c_SYNC_STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[c_SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mpi_slave_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mpi_slave_resp : MPI bus target, turns bus cycles into local mem reqs |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mpi_slave_resp
   import mpi_pkg::*;
#(
   parameter logic [15:0] BASE = 16'o160000,
   parameter logic [15:0] MASK = 16'o170000,
   parameter int unsigned WAIT = 0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] nAD_IN,
   output logic [15:0] nAD_OUT,
   output logic        AD_OE,
   input  logic        nSYNC,
   input  logic        nDIN,
   input  logic        nDOUT,
   input  logic        nWTBT,
   output logic        nRPLY,
   output logic [14:0] MEM_ADDR,
   output logic        MEM_RD,
   output logic        MEM_WE,
   output logic [1:0]  MEM_BE,
   output logic [15:0] MEM_WDATA,
   input  logic [15:0] MEM_RDATA,
   input  logic        MEM_ACK
);

   localparam logic [3:0] c_WAIT = 4'(WAIT);

   logic [15:0] w_ad_n;
   logic [3:0]  w_strb_n;
   logic        w_sync_n, w_din_n, w_dout_n, w_wtbt_n;
   logic        w_hit;

   state_t      r_state;
   logic        r_sync_q;
   logic [15:0] r_addr;
   logic [15:0] r_ad_out;
   logic        r_ad_oe;
   logic        r_rply_n;
   logic        r_mem_rd;
   logic        r_mem_we;
   logic [1:0]  r_be;
   logic [15:0] r_wdata;
   logic [3:0]  r_cnt;

   // AD and strobes share the same stage count so the data stays aligned
   mpi_sync2 #(.WIDTH(16), .RESET_VAL(16'hFFFF)) u_sync_ad (
      .clk (CLK),
      .rst (RESET),
      .i_d (nAD_IN),
      .o_q (w_ad_n)
   );

   mpi_sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_sync_strb (
      .clk (CLK),
      .rst (RESET),
      .i_d ({nSYNC, nDIN, nDOUT, nWTBT}),
      .o_q (w_strb_n)
   );

   assign {w_sync_n, w_din_n, w_dout_n, w_wtbt_n} = w_strb_n;
   assign w_hit = ((~w_ad_n & MASK) == (BASE & MASK));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= ST_IDLE;
         r_sync_q <= 1'b1;
         r_addr   <= 16'h0000;
         r_ad_out <= 16'hFFFF;
         r_ad_oe  <= 1'b0;
         r_rply_n <= 1'b1;
         r_mem_rd <= 1'b0;
         r_mem_we <= 1'b0;
         r_be     <= c_BE_NONE;
         r_wdata  <= 16'h0000;
         r_cnt    <= 4'd0;
      end else begin
         r_sync_q <= w_sync_n;
         r_mem_rd <= 1'b0;
         r_mem_we <= 1'b0;
         if (r_state != ST_IDLE && w_sync_n) begin
            r_state  <= ST_IDLE;
            r_ad_oe  <= 1'b0;
            r_rply_n <= 1'b1;
            r_ad_out <= 16'hFFFF;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (r_sync_q && !w_sync_n) begin
                     r_addr  <= ~w_ad_n;
                     r_state <= w_hit ? ST_ADDR : ST_DONE;
                  end
               end
               ST_ADDR: begin
                  if (!w_din_n) begin
                     r_mem_rd <= 1'b1;
                     r_be     <= c_BE_WORD;
                     r_state  <= ST_RD_REQ;
                  end else if (!w_dout_n) begin
                     r_wdata  <= ~w_ad_n;
                     r_be     <= !w_wtbt_n ? (r_addr[0] ? c_BE_HIGH : c_BE_LOW)
                                           : c_BE_WORD;
                     r_mem_we <= 1'b1;
                     r_state  <= ST_WR_REQ;
                  end
               end
               ST_RD_REQ: r_state <= ST_RD_WAIT;
               ST_RD_WAIT: begin
                  if (MEM_ACK) begin
                     r_ad_out <= ~MEM_RDATA;
                     r_ad_oe  <= 1'b1;
                     r_cnt    <= c_WAIT;
                     if (c_WAIT == 4'd0) r_rply_n <= 1'b0;
                     r_state  <= ST_RD_RPLY;
                  end
               end
               ST_RD_RPLY: begin
                  if (w_din_n) begin
                     r_rply_n <= 1'b1;
                     r_ad_oe  <= 1'b0;
                     r_ad_out <= 16'hFFFF;
                     r_state  <= ST_ADDR;
                  end else if (r_cnt != 4'd0) begin
                     r_cnt <= r_cnt - 4'd1;
                     if (r_cnt == 4'd1) r_rply_n <= 1'b0;
                  end
               end
               ST_WR_REQ: r_state <= ST_WR_WAIT;
               ST_WR_WAIT: begin
                  if (MEM_ACK) begin
                     r_cnt   <= c_WAIT;
                     if (c_WAIT == 4'd0) r_rply_n <= 1'b0;
                     r_state <= ST_WR_RPLY;
                  end
               end
               ST_WR_RPLY: begin
                  if (w_dout_n) begin
                     r_rply_n <= 1'b1;
                     r_state  <= ST_ADDR;
                  end else if (r_cnt != 4'd0) begin
                     r_cnt <= r_cnt - 4'd1;
                     if (r_cnt == 4'd1) r_rply_n <= 1'b0;
                  end
               end
               ST_DONE: r_state <= ST_DONE;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign nAD_OUT   = r_ad_out;
   assign AD_OE     = r_ad_oe;
   assign nRPLY     = r_rply_n;
   assign MEM_ADDR  = r_addr[15:1];
   assign MEM_RD    = r_mem_rd;
   assign MEM_WE    = r_mem_we;
   assign MEM_BE    = r_be;
   assign MEM_WDATA = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mpi_slave_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mpi_slave_resp : directed bench, bus master plus 1-cycle-ack memory |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mpi_slave_resp;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [15:0] nAD_IN = 16'hFFFF;
   logic        nSYNC = 1'b1, nDIN = 1'b1, nDOUT = 1'b1, nWTBT = 1'b1;
   logic [15:0] MEM_RDATA = 16'h0000;
   logic        MEM_ACK = 1'b0;

   logic [15:0] nAD_OUT_0, nAD_OUT_3;
   logic        AD_OE_0, AD_OE_3, nRPLY_0, nRPLY_3;
   logic [14:0] MEM_ADDR_0, MEM_ADDR_3;
   logic        MEM_RD_0, MEM_RD_3, MEM_WE_0, MEM_WE_3;
   logic [1:0]  MEM_BE_0, MEM_BE_3;
   logic [15:0] MEM_WDATA_0, MEM_WDATA_3;

   int checks = 0;
   int failures = 0;

   // memory model state, driven only from the negedge process
   int          rd_cnt = 0, we_cnt = 0, rply_falls = 0, rply_lo = 0, oe_hi = 0;
   logic        pend = 1'b0, rply_prev = 1'b1;
   logic        ack_en = 1'b1, ack_force = 1'b0;
   logic [14:0] cap_addr = '0;
   logic [15:0] cap_wdata = '0;
   logic [1:0]  cap_be = '0;

   always #5 CLK = ~CLK;

   mpi_slave_resp #(.BASE(16'o160000), .MASK(16'o170000), .WAIT(0)) dut (
      .CLK(CLK), .RESET(RESET), .nAD_IN(nAD_IN), .nAD_OUT(nAD_OUT_0), .AD_OE(AD_OE_0),
      .nSYNC(nSYNC), .nDIN(nDIN), .nDOUT(nDOUT), .nWTBT(nWTBT), .nRPLY(nRPLY_0),
      .MEM_ADDR(MEM_ADDR_0), .MEM_RD(MEM_RD_0), .MEM_WE(MEM_WE_0), .MEM_BE(MEM_BE_0),
      .MEM_WDATA(MEM_WDATA_0), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
   );

   mpi_slave_resp #(.BASE(16'o160000), .MASK(16'o170000), .WAIT(3)) dut_w3 (
      .CLK(CLK), .RESET(RESET), .nAD_IN(nAD_IN), .nAD_OUT(nAD_OUT_3), .AD_OE(AD_OE_3),
      .nSYNC(nSYNC), .nDIN(nDIN), .nDOUT(nDOUT), .nWTBT(nWTBT), .nRPLY(nRPLY_3),
      .MEM_ADDR(MEM_ADDR_3), .MEM_RD(MEM_RD_3), .MEM_WE(MEM_WE_3), .MEM_BE(MEM_BE_3),
      .MEM_WDATA(MEM_WDATA_3), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
   );

   // ack lands in the cycle after each strobe of the WAIT=0 instance
   always @(negedge CLK) begin
      MEM_ACK = (ack_en && pend) || ack_force;
      pend    = MEM_RD_0 || MEM_WE_0;
      if (MEM_RD_0) begin
         rd_cnt++;
         cap_addr = MEM_ADDR_0;
         cap_be   = MEM_BE_0;
      end
      if (MEM_WE_0) begin
         we_cnt++;
         cap_addr  = MEM_ADDR_0;
         cap_be    = MEM_BE_0;
         cap_wdata = MEM_WDATA_0;
      end
      if (!nRPLY_0 && rply_prev) rply_falls++;
      rply_prev = nRPLY_0;
      if (!nRPLY_0) rply_lo++;
      if (AD_OE_0) oe_hi++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // edges counted from the one that first samples the changed pin
   task automatic wait_rply(input logic level, output int n);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (nRPLY_0 !== level && n < 30);
   endtask

   task automatic addr_phase(input logic [15:0] a);
      nAD_IN = ~a;
      nSYNC  = 1'b0;
      tick(4);
      nAD_IN = 16'hFFFF;
   endtask

   task automatic end_cycle();
      nSYNC  = 1'b1;
      nDIN   = 1'b1;
      nDOUT  = 1'b1;
      nWTBT  = 1'b1;
      nAD_IN = 16'hFFFF;
      tick(4);
   endtask

   initial begin
      int n, n0, b_rd, b_we, b_rf, b_lo, b_oe;

      // reset with random bus activity
      RESET = 1'b1;
      repeat (3) begin
         tick(1);
         nAD_IN = 16'($urandom);
         {nSYNC, nDIN, nDOUT, nWTBT} = 4'($urandom);
      end
      check("rst_nrply", nRPLY_0, 1'b1);
      check("rst_adoe", AD_OE_0, 1'b0);
      check("rst_nadout", nAD_OUT_0, 16'hFFFF);
      check("rst_memrd", MEM_RD_0, 1'b0);
      check("rst_memwe", MEM_WE_0, 1'b0);
      check("rst_membe", MEM_BE_0, 2'b00);
      check("rst_memaddr", MEM_ADDR_0, 15'h0000);
      check("rst_wdata", MEM_WDATA_0, 16'h0000);
      end_cycle();
      RESET = 1'b0;
      tick(3);
      check("rst_no_strobes", rd_cnt + we_cnt, 0);

      // word read at 0o160010
      MEM_RDATA = 16'h1234;
      b_rd = rd_cnt;
      addr_phase(16'o160010);
      nDIN = 1'b0;
      wait_rply(1'b0, n);
      check("rd_latency", n - 1, 4);
      check("rd_nadout", nAD_OUT_0, 16'hEDCB);
      check("rd_adoe", AD_OE_0, 1'b1);
      check("rd_addr", cap_addr, 15'h7004);
      check("rd_be", cap_be, 2'b11);
      nDIN = 1'b1;
      wait_rply(1'b1, n);
      check("rd_release", n - 1, 2);
      check("rd_adoe_drop", AD_OE_0, 1'b0);
      check("rd_one_pulse", rd_cnt - b_rd, 1);
      end_cycle();

      // word write 0xA55A at 0o160020
      b_we = we_cnt;
      addr_phase(16'o160020);
      nAD_IN = ~16'hA55A;
      nDOUT  = 1'b0;
      wait_rply(1'b0, n);
      check("wr_latency", n - 1, 4);
      check("wr_pulse", we_cnt - b_we, 1);
      check("wr_be", cap_be, 2'b11);
      check("wr_wdata", cap_wdata, 16'hA55A);
      check("wr_addr", cap_addr, 15'h7008);
      nDOUT = 1'b1;
      wait_rply(1'b1, n);
      check("wr_release", n - 1, 2);
      end_cycle();

      // byte write, odd then even address
      addr_phase(16'o160021);
      nAD_IN = ~16'h3400;
      nWTBT  = 1'b0;
      nDOUT  = 1'b0;
      wait_rply(1'b0, n);
      check("bwr_odd_be", cap_be, 2'b10);
      check("bwr_odd_wdata", cap_wdata, 16'h3400);
      end_cycle();
      addr_phase(16'o160020);
      nAD_IN = ~16'h0034;
      nWTBT  = 1'b0;
      nDOUT  = 1'b0;
      wait_rply(1'b0, n);
      check("bwr_even_be", cap_be, 2'b01);
      end_cycle();

      // read outside the window
      b_rd = rd_cnt; b_lo = rply_lo; b_oe = oe_hi;
      addr_phase(16'o140000);
      nDIN = 1'b0;
      tick(12);
      check("unsel_no_rd", rd_cnt - b_rd, 0);
      check("unsel_no_rply", rply_lo - b_lo, 0);
      check("unsel_no_oe", oe_hi - b_oe, 0);
      end_cycle();

      // read-modify-write under one SYNC
      b_rd = rd_cnt; b_we = we_cnt; b_rf = rply_falls;
      MEM_RDATA = 16'h5555;
      addr_phase(16'o160010);
      nDIN = 1'b0;
      wait_rply(1'b0, n);
      check("rmw_rdata", nAD_OUT_0, 16'hAAAA);
      nDIN = 1'b1;
      wait_rply(1'b1, n);
      nAD_IN = ~16'h00FF;
      nDOUT  = 1'b0;
      wait_rply(1'b0, n);
      check("rmw_wr_latency", n - 1, 4);
      nDOUT = 1'b1;
      wait_rply(1'b1, n);
      check("rmw_rd_cnt", rd_cnt - b_rd, 1);
      check("rmw_we_cnt", we_cnt - b_we, 1);
      check("rmw_wdata", cap_wdata, 16'h00FF);
      check("rmw_replies", rply_falls - b_rf, 2);
      end_cycle();

      // SYNC dropped while waiting for ack; late ack must be ignored
      b_rd = rd_cnt; b_lo = rply_lo; b_oe = oe_hi;
      ack_en = 1'b0;
      addr_phase(16'o160010);
      nDIN = 1'b0;
      tick(6);
      nSYNC = 1'b1;
      nDIN  = 1'b1;
      tick(3);
      ack_force = 1'b1;
      tick(2);
      ack_force = 1'b0;
      ack_en    = 1'b1;
      tick(3);
      check("abort_rd_cnt", rd_cnt - b_rd, 1);
      check("abort_no_rply", rply_lo - b_lo, 0);
      check("abort_no_oe", oe_hi - b_oe, 0);
      MEM_RDATA = 16'h0F0F;
      addr_phase(16'o160010);
      nDIN = 1'b0;
      wait_rply(1'b0, n);
      check("abort_then_read", n - 1, 4);
      check("abort_then_data", nAD_OUT_0, 16'hF0F0);
      end_cycle();

      // WAIT=3 instance replies exactly 3 cycles after the WAIT=0 one
      MEM_RDATA = 16'hBEEF;
      addr_phase(16'o160010);
      nDIN = 1'b0;
      n = 0; n0 = 0;
      do begin
         tick(1);
         n++;
         if (n0 == 0 && nRPLY_0 === 1'b0) n0 = n;
      end while (nRPLY_3 !== 1'b0 && n < 40);
      check("w3_latency", n - 1, 7);
      check("w3_delta", n - n0, 3);
      check("w3_nadout", nAD_OUT_3, 16'h4110);
      check("w3_adoe", AD_OE_3, 1'b1);

      // reset in the middle of a replying read
      RESET = 1'b1;
      tick(1);
      check("midrst_nrply", nRPLY_0, 1'b1);
      check("midrst_adoe", AD_OE_0, 1'b0);
      check("midrst_nadout", nAD_OUT_0, 16'hFFFF);
      check("midrst_w3_nrply", nRPLY_3, 1'b1);
      end_cycle();
      RESET = 1'b0;
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
